// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param. The FIFO takes the slave
// side. The surrounding logic, or a bench, drives the master side.
interface sync_fifo_param_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             err_clr;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, err_clr,
        input  rdata, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, err_clr,
        output rdata, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO. It provides an occupancy count,
// almost-full and almost-empty thresholds, and a choice of
// first-word-fall-through or registered read. It also has sticky
// overflow and underflow error flags.
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 1
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int DEPTH = 1 << ASIZE;

    typedef logic [ASIZE:0] ptr_t;

    localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
    localparam ptr_t AFULL_C  = ptr_t'(AFULL_TH);
    localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_TH);
    localparam ptr_t ONE_C    = ptr_t'(1);

    // Reject nonsensical configurations at elaboration time.
    if (ASIZE < 1) begin : g_bad_asize
        $error("sync_fifo_param: ASIZE must be >= 1 (got %0d)", ASIZE);
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must be in 1..%0d (got %0d)", DEPTH, AFULL_TH);
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must be in 0..%0d (got %0d)", DEPTH - 1, AEMPTY_TH);
    end

    // Storage is intentionally left without a reset.
    logic [DSIZE-1:0] mem_q [DEPTH];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic             full, empty;
    logic             wr_ok, rd_ok;
    logic [DSIZE-1:0] head_word;

    // The flags decode directly from count, so they follow the causing
    // edge with no extra latency.
    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
    end

    // Accept decisions use the flags as they were before the edge. Any
    // request made while reset is asserted is ignored.
    always_comb begin
        wr_ok     = bus.winc & ~full  & ~rst;
        rd_ok     = bus.rinc & ~empty & ~rst;
        head_word = mem_q[rptr_q[ASIZE-1:0]];
    end

    // Next-state logic for the pointers, the count and the sticky errors.
    // When a set and a clear happen in the same cycle, the set wins.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  & ~bus.err_clr;
        underflow_d = underflow_q & ~bus.err_clr;
        if (wr_ok) wptr_d = wptr_q + ONE_C;
        if (rd_ok) rptr_d = rptr_q + ONE_C;
        if (wr_ok && !rd_ok) count_d = count_q + ONE_C;
        if (rd_ok && !wr_ok) count_d = count_q - ONE_C;
        if (bus.winc && full)  overflow_d  = 1'b1;
        if (bus.rinc && empty) underflow_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port. A write that is rejected, or that arrives
    // during reset, leaves the memory untouched.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q[ASIZE-1:0]] <= bus.wdata;
    end

    // Occupancy must always equal the pointer distance. The full pointer
    // width is compared so that the wrap bit is covered as well.
    always_ff @(posedge clk) begin
        if (!rst) assert (count_q == ptr_t'(wptr_q - rptr_q));
    end

    if (FWFT != 0) begin : g_fwft
        // The head word is shown directly. It is valid whenever the FIFO
        // is not empty.
        always_comb begin
            bus.rdata = head_word;
        end
    end else begin : g_reg_read
        logic [DSIZE-1:0] rdata_q, rdata_d;

        // The output register loads only on an accepted pop. Otherwise it
        // holds its value.
        always_comb begin
            rdata_d = rdata_q;
            if (rd_ok) rdata_d = head_word;
        end

        // Registered read data. It clears on reset.
        always_ff @(posedge clk) begin
            if (rst) rdata_q <= '0;
            else     rdata_q <= rdata_d;
        end

        always_comb begin
            bus.rdata = rdata_q;
        end
    end

    // Drive the status outputs.
    always_comb begin
        bus.wfull         = full;
        bus.rempty        = empty;
        bus.walmost_full  = (count_q >= AFULL_C);
        bus.ralmost_empty = (count_q <= AEMPTY_C);
        bus.count         = count_q;
        bus.overflow      = overflow_q;
        bus.underflow     = underflow_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param. One instance uses FWFT=1 and one
// uses registered read. Both use the default 16-entry configuration.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst1, rst0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) bus1 ();
    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) bus0 ();

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1))
        dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0))
        dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    // Advance one rising edge. Inputs are applied and outputs are sampled
    // 1 time unit after that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        bus1.winc = 1'b0; bus1.rinc = 1'b0; bus1.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; bus1.winc = 1'b1; bus1.rinc = 1'b1; bus1.err_clr = 1'b0; bus1.wdata = 8'h55;
        step(); step();
        checks++; if (bus1.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus1.count); end
        checks++; if (bus1.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%b exp=1", bus1.rempty); end
        checks++; if (bus1.wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%b exp=0", bus1.wfull); end
        checks++; if (bus1.ralmost_empty !== 1'b1) begin failures++; $display("FAIL reset_raempty got=%b exp=1", bus1.ralmost_empty); end
        checks++; if (bus1.walmost_full !== 1'b0) begin failures++; $display("FAIL reset_wafull got=%b exp=0", bus1.walmost_full); end
        checks++; if ({bus1.overflow, bus1.underflow} !== 2'b00) begin
            failures++; $display("FAIL reset_errs got=%b%b exp=00", bus1.overflow, bus1.underflow);
        end
        rst1 = 1'b0; idle1();
        step();
        checks++; if (bus1.count !== 5'd0) begin failures++; $display("FAIL reset_release_count got=%0d exp=0", bus1.count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            bus1.wdata = 8'(i); bus1.winc = 1'b1;
            step();
            checks++; if (bus1.count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus1.count, i + 1); end
            checks++; if (bus1.walmost_full !== (i + 1 >= 12)) begin
                failures++; $display("FAIL fill_wafull[%0d] got=%b exp=%b", i, bus1.walmost_full, (i + 1 >= 12));
            end
            checks++; if (bus1.wfull !== (i + 1 == 16)) begin
                failures++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, bus1.wfull, (i + 1 == 16));
            end
            checks++; if (bus1.rdata !== 8'h00) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=00", i, bus1.rdata); end
        end
        bus1.wdata = 8'hEE;
        step();
        checks++; if (bus1.overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", bus1.overflow); end
        checks++; if (bus1.count !== 5'd16) begin failures++; $display("FAIL fill_ovf_count got=%0d exp=16", bus1.count); end
        checks++; if (bus1.rdata !== 8'h00) begin failures++; $display("FAIL fill_ovf_head got=%h exp=00", bus1.rdata); end
        idle1();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus1.rdata !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus1.rdata, 8'(i)); end
            bus1.rinc = 1'b1;
            step();
            checks++; if (bus1.count !== 5'(15 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus1.count, 15 - i); end
            checks++; if (bus1.rempty !== (i == 15)) begin failures++; $display("FAIL drain_rempty[%0d] got=%b exp=%b", i, bus1.rempty, (i == 15)); end
            checks++; if (bus1.ralmost_empty !== (15 - i <= 2)) begin
                failures++; $display("FAIL drain_raempty[%0d] got=%b exp=%b", i, bus1.ralmost_empty, (15 - i <= 2));
            end
        end
        step();
        checks++; if (bus1.underflow !== 1'b1) begin failures++; $display("FAIL drain_underflow got=%b exp=1", bus1.underflow); end
        checks++; if (bus1.overflow !== 1'b1) begin failures++; $display("FAIL drain_ovf_sticky got=%b exp=1", bus1.overflow); end
        checks++; if (bus1.count !== 5'd0) begin failures++; $display("FAIL drain_udf_count got=%0d exp=0", bus1.count); end
        bus1.rinc = 1'b0; bus1.err_clr = 1'b1;
        step();
        checks++; if ({bus1.overflow, bus1.underflow} !== 2'b00) begin
            failures++; $display("FAIL drain_errclr got=%b%b exp=00", bus1.overflow, bus1.underflow);
        end
        idle1();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            bus1.wdata = 8'h20 + 8'(i); bus1.winc = 1'b1;
            step();
        end
        bus1.wdata = 8'h25; bus1.rinc = 1'b1;
        step();
        checks++; if (bus1.count !== 5'd5) begin failures++; $display("FAIL simul_mid_count got=%0d exp=5", bus1.count); end
        checks++; if (bus1.rdata !== 8'h21) begin failures++; $display("FAIL simul_mid_head got=%h exp=21", bus1.rdata); end
        bus1.rinc = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus1.wdata = 8'h26 + 8'(i);
            step();
        end
        checks++; if (bus1.wfull !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", bus1.wfull); end
        bus1.wdata = 8'h77; bus1.rinc = 1'b1;
        step();
        checks++; if (bus1.count !== 5'd15) begin failures++; $display("FAIL simul_full_count got=%0d exp=15", bus1.count); end
        checks++; if (bus1.overflow !== 1'b1) begin failures++; $display("FAIL simul_full_ovf got=%b exp=1", bus1.overflow); end
        checks++; if (bus1.rdata !== 8'h22) begin failures++; $display("FAIL simul_full_head got=%h exp=22", bus1.rdata); end
        idle1(); bus1.err_clr = 1'b1;
        step();
        bus1.err_clr = 1'b0; bus1.rinc = 1'b1;
        for (int i = 0; i < 15; i++) step();
        checks++; if (bus1.rempty !== 1'b1) begin failures++; $display("FAIL simul_drained got=%b exp=1", bus1.rempty); end
        bus1.winc = 1'b1; bus1.wdata = 8'h99;
        step();
        checks++; if (bus1.count !== 5'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", bus1.count); end
        checks++; if (bus1.underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_udf got=%b exp=1", bus1.underflow); end
        checks++; if (bus1.rdata !== 8'h99) begin failures++; $display("FAIL simul_empty_head got=%h exp=99", bus1.rdata); end
        bus1.winc = 1'b0; bus1.rinc = 1'b1; bus1.err_clr = 1'b1;
        step();
        checks++; if ({bus1.count, bus1.underflow} !== {5'd0, 1'b0}) begin
            failures++; $display("FAIL simul_cleanup got=%0d/%b exp=0/0", bus1.count, bus1.underflow);
        end
        idle1();
    endtask

    task automatic test_interleave();
        logic [7:0] q[$];
        int wr = 0, rd = 0, cyc = 0;
        logic do_w, do_r;
        while ((wr < 40 || rd < 40) && cyc < 600) begin
            do_w = (wr < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
            do_r = (q.size() > 0) && ($urandom_range(0, 1) != 0);
            if (do_r) begin
                checks++; if (bus1.rdata !== q[0]) begin failures++; $display("FAIL ilv_data[%0d] got=%h exp=%h", rd, bus1.rdata, q[0]); end
            end
            bus1.winc = do_w; bus1.rinc = do_r; bus1.wdata = 8'h40 + 8'(wr);
            step();
            if (do_w) begin q.push_back(8'h40 + 8'(wr)); wr++; end
            if (do_r) begin void'(q.pop_front()); rd++; end
            checks++; if (bus1.count !== 5'(wr - rd)) begin failures++; $display("FAIL ilv_count got=%0d exp=%0d", bus1.count, wr - rd); end
            checks++; if (bus1.rempty !== (wr == rd)) begin failures++; $display("FAIL ilv_rempty got=%b exp=%b", bus1.rempty, (wr == rd)); end
            cyc++;
        end
        checks++; if (cyc >= 600) begin failures++; $display("FAIL ilv_timeout got=%0d exp<600 cycles", cyc); end
        checks++; if ({bus1.overflow, bus1.underflow} !== 2'b00) begin
            failures++; $display("FAIL ilv_errs got=%b%b exp=00", bus1.overflow, bus1.underflow);
        end
        idle1();
    endtask

    task automatic test_registered_read();
        bus0.winc = 1'b0; bus0.rinc = 1'b0; bus0.err_clr = 1'b0; bus0.wdata = 8'h00;
        rst0 = 1'b1;
        step();
        checks++; if (bus0.rdata !== 8'h00) begin failures++; $display("FAIL reg_reset_rdata got=%h exp=00", bus0.rdata); end
        rst0 = 1'b0; bus0.winc = 1'b1; bus0.wdata = 8'hA5;
        step();
        checks++; if ({bus0.count, bus0.rdata} !== {5'd1, 8'h00}) begin
            failures++; $display("FAIL reg_after_write got=%0d/%h exp=1/00", bus0.count, bus0.rdata);
        end
        bus0.winc = 1'b0; bus0.rinc = 1'b1;
        step();
        checks++; if (bus0.rdata !== 8'hA5) begin failures++; $display("FAIL reg_rdata got=%h exp=a5", bus0.rdata); end
        checks++; if (bus0.rempty !== 1'b1) begin failures++; $display("FAIL reg_rempty got=%b exp=1", bus0.rempty); end
        bus0.rinc = 1'b0;
        step();
        checks++; if (bus0.rdata !== 8'hA5) begin failures++; $display("FAIL reg_hold got=%h exp=a5", bus0.rdata); end
        bus0.winc = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus0.wdata = 8'h10 + 8'(i);
            step();
        end
        checks++; if (bus0.count !== 5'd7) begin failures++; $display("FAIL reg_count7 got=%0d exp=7", bus0.count); end
        rst0 = 1'b1;
        step();
        checks++; if ({bus0.count, bus0.rdata, bus0.rempty} !== {5'd0, 8'h00, 1'b1}) begin
            failures++; $display("FAIL reg_midreset got=%0d/%h/%b exp=0/00/1", bus0.count, bus0.rdata, bus0.rempty);
        end
        checks++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin
            failures++; $display("FAIL reg_midreset_errs got=%b%b exp=00", bus0.overflow, bus0.underflow);
        end
        rst0 = 1'b0; bus0.winc = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1;
        bus0.winc = 1'b0; bus0.rinc = 1'b0; bus0.err_clr = 1'b0; bus0.wdata = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_interleave();
        test_registered_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
